// File: rtl/lkup_pkg.sv
// Shared definitions for the per-stage TCAM lookup engine.
// Holds the default PHV/key/action widths, the miss action word and the
// layout of one ternary table entry {vld, key, mask} for the default widths.
package lkup_pkg;

  localparam int LKUP_PHV_W = 1124;
  localparam int LKUP_KEY_W = 197;
  localparam int LKUP_ACT_W = 625;

  // Action emitted when no table entry matches.
  localparam logic [LKUP_ACT_W-1:0] LKUP_DEFAULT_ACT = 625'h3f;

  // mask bit 1 = compare this key bit, 0 = don't care.
  typedef struct packed {
    logic                  vld;
    logic [LKUP_KEY_W-1:0] key;
    logic [LKUP_KEY_W-1:0] mask;
  } lkup_entry_t;

endpackage

// File: rtl/lkup_prio_enc.sv
// Match-vector priority encoder for the TCAM lookup engine.
// Converts a DEPTH-wide match vector into {hit, addr}; the lowest set index
// wins. addr is 0 when nothing matches.
// Ports:
//   match  in   DEPTH   one bit per table entry
//   hit    out  1       any entry matched
//   addr   out  ADDR_W  index of the lowest matching entry
module lkup_prio_enc #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  match,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  always_comb begin
    hit  = |match;
    addr = '0;
    // Scan from the top so the lowest matching index is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) addr = ADDR_W'(i);
    end
  end

endmodule

// File: rtl/lookup_engine_tcam.sv
// Pipelined ternary-match lookup engine for one match-action stage.
// A DEPTH-entry ternary table (key/mask/valid) selects an entry for each
// incoming key; the action RAM word of the lowest matching entry (or
// DEFAULT_ACT on a miss) is returned with the PHV 3 cycles after acceptance.
// One global advance enable (adv) moves every stage, so a stalled output
// freezes the whole pipe and no beat is lost or duplicated.
// Optional build macro LKUP_STATS_EN adds saturating hit/miss counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   key_in/phv_in/key_valid  lookup request, key_ready = engine can accept
//   action/phv_out/hit/hit_addr/action_valid, action_ready  lookup result
//   tcam_wr_*                table entry write port (key, mask, valid)
//   act_wr_*                 action RAM write port
//   stat_clr, stat_hit_cnt, stat_miss_cnt  (LKUP_STATS_EN only)
module lookup_engine_tcam
  import lkup_pkg::*;
#(
  parameter  int               STAGE       = 0,
  parameter  int               PHV_W       = LKUP_PHV_W,
  parameter  int               KEY_W       = LKUP_KEY_W,
  parameter  int               ACT_W       = LKUP_ACT_W,
  parameter  int               DEPTH       = 16,
  parameter  logic [ACT_W-1:0] DEFAULT_ACT = ACT_W'(LKUP_DEFAULT_ACT),
  localparam int               ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LKUP_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_hit_cnt,
  output logic [31:0]       stat_miss_cnt,
`endif
  input  logic [KEY_W-1:0]  key_in,
  input  logic [PHV_W-1:0]  phv_in,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [ACT_W-1:0]  action,
  output logic [PHV_W-1:0]  phv_out,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_addr,
  output logic              action_valid,
  input  logic              action_ready,
  input  logic              tcam_wr_en,
  input  logic [ADDR_W-1:0] tcam_wr_addr,
  input  logic [KEY_W-1:0]  tcam_wr_key,
  input  logic [KEY_W-1:0]  tcam_wr_mask,
  input  logic              tcam_wr_vld,
  input  logic              act_wr_en,
  input  logic [ADDR_W-1:0] act_wr_addr,
  input  logic [ACT_W-1:0]  act_wr_data
);

  // STAGE only tags this instance for software/statistics; it has no logic.
  if (STAGE < 0) begin : g_stage_tag
  end

  logic adv;
  assign adv       = ~action_valid | action_ready;
  assign key_ready = adv & ~rst;

  // Ternary table: valid bits are reset, key/mask storage is not.
  logic [DEPTH-1:0] tbl_vld;
  logic [KEY_W-1:0] tbl_key  [DEPTH];
  logic [KEY_W-1:0] tbl_mask [DEPTH];
  logic [ACT_W-1:0] act_ram  [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tbl_vld <= '0;
    else if (tcam_wr_en) tbl_vld[tcam_wr_addr] <= tcam_wr_vld;
  end

  always_ff @(posedge clk) begin
    if (tcam_wr_en) begin
      tbl_key[tcam_wr_addr]  <= tcam_wr_key;
      tbl_mask[tcam_wr_addr] <= tcam_wr_mask;
    end
    if (act_wr_en) act_ram[act_wr_addr] <= act_wr_data;
  end

  // ---- S1: request capture ----
  logic             vld_p0, vld_p1, vld_p2;
  logic [KEY_W-1:0] key_p0;
  logic [PHV_W-1:0] phv_p0, phv_p1, phv_p2;

  // ---- S2: ternary compare against current (pre-write) table ----
  logic [DEPTH-1:0]  match_p0;
  logic              enc_hit;
  logic [ADDR_W-1:0] enc_addr;
  logic              hit_p1, hit_p2;
  logic [ADDR_W-1:0] addr_p1, addr_p2;

  always_comb begin
    match_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_p0[i] = tbl_vld[i] & (((key_p0 ^ tbl_key[i]) & tbl_mask[i]) == '0);
    end
  end

  lkup_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
    .match (match_p0),
    .hit   (enc_hit),
    .addr  (enc_addr)
  );

  // ---- S3: registered action RAM read (read-first against writes) ----
  logic [ACT_W-1:0] ram_q_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= key_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      key_p0   <= key_in;
      phv_p0   <= phv_in;
      hit_p1   <= enc_hit;
      addr_p1  <= enc_addr;
      phv_p1   <= phv_p0;
      ram_q_p2 <= act_ram[addr_p1];
      hit_p2   <= hit_p1;
      addr_p2  <= addr_p1;
      phv_p2   <= phv_p1;
    end
  end

  // ---- Output register: holds the last delivered beat across bubbles ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      action_valid <= 1'b0;
      action       <= '0;
      phv_out      <= '0;
      hit          <= 1'b0;
      hit_addr     <= '0;
    end else if (adv) begin
      action_valid <= vld_p2;
      if (vld_p2) begin
        action   <= hit_p2 ? ram_q_p2 : DEFAULT_ACT;
        phv_out  <= phv_p2;
        hit      <= hit_p2;
        hit_addr <= addr_p2;
      end
    end
  end

`ifdef LKUP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic xfer_out;
  assign xfer_out = action_valid & action_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (stat_clr) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (xfer_out) begin
      if (hit) stat_hit_cnt  <= sat_inc(stat_hit_cnt);
      else     stat_miss_cnt <= sat_inc(stat_miss_cnt);
    end
  end
`endif

endmodule

// File: doc/lookup_engine_tcam.md
Name: lookup_engine_tcam

Overview:
- Parametrised, fully pipelined successor to the stage lookup engine.
- Holds a DEPTH-entry ternary match table (key, mask and valid bit per entry) and a DEPTH-deep action RAM; a runtime control port writes both.
- Accepts one key/PHV per cycle with valid/ready backpressure and returns action, hit and hit_addr with a fixed 3-cycle latency; sits between key extractor and action engine in each stage.

Parameters:
- STAGE, 0, stage index (informational; tags stats).
- PHV_W, 1124, PHV width.
- KEY_W, 197, key width.
- ACT_W, 625, action width.
- DEPTH, 16, table entries; power of two, 2..256.
- DEFAULT_ACT, 625'h3f, action emitted on miss.
- ADDR_W, localparam = $clog2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- key_in  in  KEY_W  lookup key
- phv_in  in  PHV_W  PHV accompanying key
- key_valid  in  1  key/PHV valid
- key_ready  out  1  engine can accept
- action  out  ACT_W  resulting action
- phv_out  out  PHV_W  PHV delayed to match action
- hit  out  1  table hit
- hit_addr  out  ADDR_W  matching entry index (0 on miss)
- action_valid  out  1  output valid
- action_ready  in  1  downstream accepts
- tcam_wr_en  in  1  table entry write strobe
- tcam_wr_addr  in  ADDR_W  entry index
- tcam_wr_key  in  KEY_W  entry key
- tcam_wr_mask  in  KEY_W  1 = bit compared, 0 = don't care
- tcam_wr_vld  in  1  entry valid bit written with entry
- act_wr_en  in  1  action RAM write strobe
- act_wr_addr  in  ADDR_W  action index
- act_wr_data  in  ACT_W  action word

Behaviour:
- Reset (async on rst=1): all pipeline valids 0; key_ready 0 during reset, 1 on the first cycle after; action, phv_out, hit, hit_addr all 0; action_valid 0; all entry valid bits 0.
- Key and mask storage is not reset. Action RAM contents are undefined until written.
- Advance enable: adv = ~action_valid | action_ready. key_ready = adv.
- When adv=0 every stage holds, including the outputs. A transfer occurs on key_valid & key_ready.
- S1: registers key, phv and a valid bit.
- S2: per entry i, match_i = vld_i & (((key ^ entry_key_i) & entry_mask_i) == 0). The lowest matching index wins (priority encoder). S2 registers hit, hit_addr and phv.
- S3: the action RAM is a registered read at hit_addr. Output action = hit ? ram[hit_addr] : DEFAULT_ACT.
- Latency: a key accepted at edge N gives action_valid=1 after edge N+3 when no stall occurs. Throughput is 1 per cycle.
- Backpressure: outputs stay stable while action_valid & ~action_ready. No beat is dropped or duplicated.
- Table write vs. lookup: the write commits at the clock edge. A key in S2 in the same cycle compares against the pre-write contents.
- Action write vs. read at the same address in the same cycle: read-first, so the old data is returned.
- Simultaneous table writes to different addresses are impossible (single port). A write with tcam_wr_vld=0 invalidates the entry.
- A mask of all 0 on a valid entry matches every key.
- Writes are accepted regardless of adv or stall.
- Reset mid-operation clears all in-flight beats; no output follows reset.

Optional Feature:
- LKUP_STATS_EN defined: adds outputs stat_hit_cnt[31:0] and stat_miss_cnt[31:0] and input stat_clr.
  - A counter increments once per output transfer (action_valid & action_ready), according to hit.
  - Counters saturate at 32'hFFFF_FFFF.
  - stat_clr=1 zeroes both on that edge and takes priority over an increment.
  - rst clears both counters.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lkup_pkg: PHV_W, KEY_W and ACT_W defaults, DEFAULT_ACT, and the entry struct typedef {vld, key, mask}.
- One sub-module, lkup_prio_enc: a combinational DEPTH-wide match vector to {hit, addr} encoder, lowest index first.
- Table and action RAM are inferred in the top.

Test Plan:
- Reset, then lookup on the empty table with key=0x1 → hit=0, action=0x3f, hit_addr=0, 3 cycles after accept.
- Write entry 5 {key=0xABC, mask all ones, vld=1} and action 5 = 0x1234; send key=0xABC → hit=1, hit_addr=5, action=0x1234.
- Add entry 2 with mask=0 (wildcard) and action 2 = 0x77; send key=0xABC → hit_addr=2, action=0x77 (lower index wins).
- Send 8 back-to-back keys with action_ready low for cycles 4-6 → 8 outputs in order, PHVs paired correctly, no loss, outputs stable while stalled.
- Invalidate entry 2 (tcam_wr_vld=0) in the cycle key=0xABC is in S2 → that beat hits 2; the next identical key hits 5.
- LKUP_STATS_EN: 3 hits and 2 misses → stat_hit_cnt=3, stat_miss_cnt=2; pulse stat_clr → both 0.
